cordic_xy_rot: RTL and testbench
================================

# cordic_xy_rot

Iterative x/y rotation datapath for the CORDIC engine, directly downstream of the angle (z) accumulator stage `cordic_comp`. Each rotation cycle, the z stage supplies one direction bit, derived from the sign of its current residual angle. This block applies the matching shift-add micro-rotation to the x/y vector. After `NUM_ITER` iterations it presents the un-normalised rotated vector with a one-cycle `done` strobe.

## Interface
- `BIT_WIDTH`, 8: width of x/y data, two's complement signed.
- `NUM_ITER`, 6: number of micro-rotations. Legal range 1 .. `BIT_WIDTH`-1.
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: load `x_in`/`y_in` and begin rotation. Honoured only in IDLE or DONE.
- `x_in`  in  `BIT_WIDTH`: initial x, signed.
- `y_in`  in  `BIT_WIDTH`: initial y, signed.
- `dir_in`  in  1: direction for the current iteration. 1 means z ≥ 0 (σ=+1); 0 means z < 0 (σ=−1).
- `iter_idx`  out  clog2(`NUM_ITER`+1): index of the iteration being applied this cycle. The z stage aligns to this index.
- `busy`  out  1: high while in ROTATE.
- `done`  out  1: one-cycle strobe in DONE.
- `x_out`  out  `BIT_WIDTH`: rotated x, signed.
- `y_out`  out  `BIT_WIDTH`: rotated y, signed.

## Operation
- FSM states: IDLE, ROTATE, DONE.
  - IDLE → ROTATE on `start`.
  - ROTATE → DONE after iteration `NUM_ITER`-1 is applied.
  - DONE → ROTATE if `start`; otherwise DONE → IDLE.
- Load (at the edge where `start` is accepted):
  - x_reg ← `x_in`, y_reg ← `y_in`, iter ← 0.
- Iteration i (each ROTATE edge; σ from `dir_in` sampled at that edge):
  - x' = x − σ·(y >>> i)
  - y' = y + σ·(x >>> i)
  - iter ← iter+1
- Arithmetic rules:
  - `>>>` is an arithmetic shift, so −1 >>> k = −1.
  - Adds wrap modulo 2^`BIT_WIDTH`; there is no saturation.
  - No gain compensation is applied, so the result is scaled by K≈1.647. The caller pre-scales inputs so that |x|,|y|·1.65 < 2^(`BIT_WIDTH`−1).
- `x_out`/`y_out` are separate registers. They update only on the edge entering DONE and hold until the next DONE entry.
- `start` while in ROTATE is ignored; the current operation is not disturbed.
- `rst` at any time, including mid-rotation:
  - state → IDLE
  - x_reg, y_reg, iter, `x_out`, `y_out` → 0
  - `busy`, `done` → 0
- `dir_in` is ignored outside ROTATE.

## Timing
- Reset values: `busy`=0, `done`=0, `x_out`=0, `y_out`=0, `iter_idx`=0.
- Iteration schedule, with `start` sampled high at edge t0:
  - `busy`=1 from t0 through the cycle ending at edge tN, where N = `NUM_ITER`.
  - Iterations 0..N−1 are applied at edges t1..tN.
  - `iter_idx` = i during the cycle preceding edge t(i+1).
- Completion:
  - `done`=1 for exactly the cycle after tN, with `x_out`/`y_out` valid from that cycle.
  - Latency from `start` to `done` is N+1 cycles.
- Back-to-back: `start` during DONE loads the new operands at that edge. `busy` rises the next cycle with no IDLE gap, giving a throughput of one result per N+1 cycles.

## Structure
- Shared package `cordic_pkg`:
  - state enum typedef `cordic_state_t` (IDLE/ROTATE/DONE), shared with `cordic_comp`'s control.
  - `CORDIC_BIT_WIDTH` default constant.
  - direction encoding constants `DIR_POS`=1, `DIR_NEG`=0.
- One combinational sub-module, `cordic_xy_iter`:
  - inputs: x, y, shift amount, σ.
  - outputs: x', y'.
  - The top level holds the FSM, the counter and all registers.

## Test plan
- `BIT_WIDTH`=8, `NUM_ITER`=3; reset, then `start` with x=32, y=0, `dir_in`=1,1,1 → `done` exactly 4 cycles after start edge; `x_out`=4, `y_out`=52; `busy` high 3 cycles.
- Same operands, `dir_in`=0,0,0 → `x_out`=4, `y_out`=−52.
- `NUM_ITER`=2, x=0, y=−1, `dir_in`=1,1 → `x_out`=2, `y_out`=−1 (checks that −1 >>> 1 = −1).
- Operands x=32, y=0, `dir_in`=1; `start` pulsed again at cycle 2 of ROTATE → ignored; result still (4,52) at the original time.
- `rst` asserted at the second ROTATE cycle → next cycle all outputs 0 and state IDLE. A later `start` with x=32, y=0, `dir_in`=1,1,1 gives (4,52).
- `start` held during DONE with x=16, y=0, `dir_in`=1,1,1 → no idle gap; second `done` 4 cycles later with (2,26); the first result held until then.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: control-state encoding and direction bit encoding
// used by both the z accumulator stage and the x/y rotation stage.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } cordic_state_t;

  localparam int CORDIC_BIT_WIDTH = 8;

  // Direction bit as produced by the z stage: 1 when residual angle z >= 0.
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/cordic_xy_iter.sv
// One combinational CORDIC micro-rotation: x' = x - s*(y>>>i), y' = y + s*(x>>>i).
// Sums wrap modulo 2^BIT_WIDTH by construction of the fixed-width adders.
module cordic_xy_iter
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = CORDIC_BIT_WIDTH,
  parameter int SHIFT_W   = 3
) (
  input  logic signed [BIT_WIDTH-1:0] x_i,
  input  logic signed [BIT_WIDTH-1:0] y_i,
  input  logic        [SHIFT_W-1:0]   shift_i,
  input  logic                        sigma_i,
  output logic signed [BIT_WIDTH-1:0] x_o,
  output logic signed [BIT_WIDTH-1:0] y_o
);

  logic signed [BIT_WIDTH-1:0] x_sh;
  logic signed [BIT_WIDTH-1:0] y_sh;

  // Arithmetic shifts keep the sign, so negative values floor toward -inf.
  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    if (sigma_i == DIR_POS) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
    end
  end

endmodule

// File: rtl/cordic_xy_rot.sv
// Iterative x/y rotation stage of the CORDIC engine. Applies NUM_ITER shift-add
// micro-rotations steered by dir_in, then presents the un-normalised vector with a done strobe.
module cordic_xy_rot
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = CORDIC_BIT_WIDTH,
  parameter int NUM_ITER  = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [BIT_WIDTH-1:0]               x_in,
  input  logic [BIT_WIDTH-1:0]               y_in,
  input  logic                               dir_in,
  output logic [$clog2(NUM_ITER+1)-1:0]      iter_idx,
  output logic                               busy,
  output logic                               done,
  output logic [BIT_WIDTH-1:0]               x_out,
  output logic [BIT_WIDTH-1:0]               y_out,
  output logic [1:0]                         state_dbg
);

  localparam int ITER_W = $clog2(NUM_ITER + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

  cordic_state_t state_q, state_d;

  logic signed [BIT_WIDTH-1:0] x_q, y_q;
  logic signed [BIT_WIDTH-1:0] x_nxt, y_nxt;
  logic        [BIT_WIDTH-1:0] x_out_q, y_out_q;
  logic        [ITER_W-1:0]    iter_q;
  logic                        load;
  logic                        step;
  logic                        last_step;

  cordic_xy_iter #(
    .BIT_WIDTH (BIT_WIDTH),
    .SHIFT_W   (ITER_W)
  ) u_iter (
    .x_i     (x_q),
    .y_i     (y_q),
    .shift_i (iter_q),
    .sigma_i (dir_in),
    .x_o     (x_nxt),
    .y_o     (y_nxt)
  );

  // start is only honoured in IDLE/DONE; in ROTATE the operation runs to completion.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROTATE;
          load    = 1'b1;
        end
      end
      ROTATE: begin
        step = 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d   = DONE;
          last_step = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = ROTATE;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      iter_q  <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        x_q    <= x_in;
        y_q    <= y_in;
        iter_q <= '0;
      end else if (step) begin
        x_q    <= x_nxt;
        y_q    <= y_nxt;
        iter_q <= iter_q + ITER_W'(1);
      end
      // Result registers only move on DONE entry so the previous answer stays
      // visible while a back-to-back operation is rotating.
      if (last_step) begin
        x_out_q <= x_nxt;
        y_out_q <= y_nxt;
      end
    end
  end

  assign iter_idx  = iter_q;
  assign busy      = (state_q == ROTATE);
  assign done      = (state_q == DONE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_xy_rot.sv
// Bench for cordic_xy_rot: directed and random rotations scored against an
// integer reference model through an expected-result queue.
module tb_cordic_xy_rot;
  import cordic_pkg::*;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int N2 = 2;
  localparam int EW = 32 + 2 * W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with NUM_ITER=3
  logic                       start = 1'b0;
  logic [W-1:0]               x_in = '0, y_in = '0;
  logic                       dir_in = 1'b0;
  logic [$clog2(N+1)-1:0]     iter_idx;
  logic                       busy, done;
  logic [W-1:0]               x_out, y_out;
  logic [1:0]                 state_dbg;

  cordic_xy_rot #(.BIT_WIDTH(W), .NUM_ITER(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .dir_in(dir_in),
    .iter_idx(iter_idx), .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .state_dbg(state_dbg)
  );

  // DUT with NUM_ITER=2 for the negative-shift corner
  logic                       start2 = 1'b0;
  logic [W-1:0]               x_in2 = '0, y_in2 = '0;
  logic                       dir_in2 = 1'b0;
  logic [$clog2(N2+1)-1:0]    iter_idx2;
  logic                       busy2, done2;
  logic [W-1:0]               x_out2, y_out2;
  logic [1:0]                 state_dbg2;

  cordic_xy_rot #(.BIT_WIDTH(W), .NUM_ITER(N2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_in(x_in2), .y_in(y_in2), .dir_in(dir_in2),
    .iter_idx(iter_idx2), .busy(busy2), .done(done2), .x_out(x_out2), .y_out(y_out2),
    .state_dbg(state_dbg2)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int held_x = 0, held_y = 0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // reference model: plain integer arithmetic, floor division for the shifts
  function automatic int wrap(int v);
    int m, r;
    m = 1 << W;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int floor_div_pow2(int v, int i);
    int d, q;
    d = 1 << i;
    q = v / d;
    if (v < 0 && q * d != v) q -= 1;
    return q;
  endfunction

  function automatic void model(int x0, int y0, logic [7:0] dirs, int n,
                                output int xr, output int yr);
    int x, y, s, xn, yn;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      s  = dirs[i] ? 1 : -1;
      xn = wrap(x - s * floor_div_pow2(y, i));
      yn = wrap(y + s * floor_div_pow2(x, i));
      x  = xn;
      y  = yn;
    end
    xr = x;
    yr = y;
  endfunction

  // monitor: pops one expectation per done cycle
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, int'(e[EW-1:2*W]));
        check("x_out", int'($signed(x_out)), int'($signed(e[2*W-1:W])));
        check("y_out", int'($signed(y_out)), int'($signed(e[W-1:0])));
        held_x = int'($signed(e[2*W-1:W]));
        held_y = int'($signed(e[W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_op(input int x, input int y, input logic [2:0] dirs,
                        input bit use_exp, input int ex, input int ey, input bit poke);
    int mx, my;
    @(negedge clk);
    start = 1'b1;
    x_in  = W'(x);
    y_in  = W'(y);
    if (use_exp) begin
      mx = ex;
      my = ey;
    end else begin
      model(x, y, {5'b0, dirs}, N, mx, my);
    end
    exp_q.push_back({32'(cyc + N + 1), W'(mx), W'(my)});
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      start  = (poke && i == 1);
      if (poke && i == 1) begin
        x_in = W'($urandom_range(0, 255));
        y_in = W'($urandom_range(0, 255));
      end
      dir_in = dirs[i];
      check("busy", int'(busy), 1);
      check("iter_idx", int'(iter_idx), i);
      check("held_x", int'($signed(x_out)), held_x);
      check("held_y", int'($signed(y_out)), held_y);
    end
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_iter", int'(iter_idx), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    check("rst_x2", int'(x_out2), 0);
    rst = 1'b0;

    // directed rotations
    run_op(32, 0, 3'b111, 1'b1, 4, 52, 1'b0);
    idle(2);
    run_op(32, 0, 3'b000, 1'b1, 4, -52, 1'b0);
    idle(2);
    // start pulsed mid-rotation must be ignored
    run_op(32, 0, 3'b111, 1'b1, 4, 52, 1'b1);
    idle(2);

    // reset in the second ROTATE cycle
    @(negedge clk);
    start = 1'b1; x_in = 8'd32; y_in = 8'd0;
    @(negedge clk);
    start = 1'b0; dir_in = DIR_POS;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_x", int'(x_out), 0);
    check("mid_rst_y", int'(y_out), 0);
    check("mid_rst_iter", int'(iter_idx), 0);
    check("mid_rst_state", int'(state_dbg), int'(IDLE));
    rst = 1'b0;
    held_x = 0;
    held_y = 0;
    run_op(32, 0, 3'b111, 1'b1, 4, 52, 1'b0);

    // back-to-back: start during DONE
    run_op(16, 0, 3'b111, 1'b1, 2, 26, 1'b0);
    idle(2);

    // -1 >>> 1 stays -1 (NUM_ITER=2 instance)
    @(negedge clk);
    start2 = 1'b1; x_in2 = 8'd0; y_in2 = 8'hFF;
    @(negedge clk);
    start2 = 1'b0; dir_in2 = 1'b1;
    check("n2_busy", int'(busy2), 1);
    @(negedge clk);
    dir_in2 = 1'b1;
    @(negedge clk);
    check("n2_done", int'(done2), 1);
    check("n2_x", int'($signed(x_out2)), 2);
    check("n2_y", int'($signed(y_out2)), -1);
    @(negedge clk);
    check("n2_done_strobe", int'(done2), 0);

    // random operations, random gaps (gap 0 exercises back-to-back)
    for (int k = 0; k < 30; k++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 100)) - 50;
      ry = int'($urandom_range(0, 100)) - 50;
      run_op(rx, ry, 3'($urandom_range(0, 7)), 1'b0, 0, 0, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    @(negedge clk);
    check("final_idle_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
